adc_frame_packer: RTL

- Sits between Test_Template's per-channel ADC sample outputs (o_data 160 b, o_rdy 10 b) and the 32-bit write port of the okPipeIn FIFO (fifo_w32_1024_r256_128).
- Collects one 16-bit sample from each of the 10 channels into a frame. Serialises the frame as a header word plus 5 data words.
- Throttles on FIFO fill level and counts frames it drops.
- Runs for a host-programmed number of frames per start trigger.

---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_frame_packer_if.sv | 31 +++
 rtl/adc_frame_emitter.sv | 66 ++++++
 rtl/adc_frame_packer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared sizes, header tag, FIFO threshold and run-state encoding
// for the ADC frame packer and its word emitter.
package adc_pkg;

  localparam int NUM_CH      = 10;
  localparam int SAMPLE_W    = 16;
  localparam int WORD_W      = 2 * SAMPLE_W;
  localparam int FRAME_W     = NUM_CH * SAMPLE_W;
  localparam int FRAME_WORDS = NUM_CH / 2 + 1;
  localparam int IDX_W       = $clog2(FRAME_WORDS);
  localparam int CNT_W       = 10;

  localparam logic [CNT_W-1:0]    FIFO_THRESH = 10'd1000;
  localparam logic [SAMPLE_W-1:0] HDR_TAG     = 16'hA5C3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// adc_frame_packer_if: ADC sample bus (data/rdy) plus the FIFO write port.
// master = packer side, slave = ADC/FIFO environment side.
interface adc_frame_packer_if;
  import adc_pkg::*;

  logic [FRAME_W-1:0] data;
  logic [NUM_CH-1:0]  rdy;
  logic [CNT_W-1:0]   fifo_wr_count;
  logic               fifo_full;
  logic [WORD_W-1:0]  fifo_din;
  logic               fifo_wr_en;

  modport master (
    input  data,
    input  rdy,
    input  fifo_wr_count,
    input  fifo_full,
    output fifo_din,
    output fifo_wr_en
  );

  modport slave (
    output data,
    output rdy,
    output fifo_wr_count,
    output fifo_full,
    input  fifo_din,
    input  fifo_wr_en
  );

endinterface

// File: rtl/adc_frame_emitter.sv
// adc_frame_emitter: holds one frame and serialises it as header + data words.
// Ports: i_load/i_seq/i_samples load a frame; o_busy/o_last track the burst;
// o_din/o_wr_en drive the FIFO, o_full_hit flags a word lost to i_fifo_full.
module adc_frame_emitter
  import adc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [SAMPLE_W-1:0] i_seq,
  input  logic [FRAME_W-1:0]  i_samples,
  input  logic                i_fifo_full,
  output logic                o_busy,
  output logic                o_last,
  output logic                o_full_hit,
  output logic [WORD_W-1:0]   o_din,
  output logic                o_wr_en
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  logic                r_active;
  logic [IDX_W-1:0]    r_idx;
  logic [SAMPLE_W-1:0] r_seq;
  logic [FRAME_W-1:0]  r_buf;

  logic                w_last;
  logic [WORD_W-1:0]   w_word;

  assign w_last = r_active && (r_idx == LAST_IDX);

  // A full FIFO never stalls the burst: the word is dropped and we move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_idx    <= '0;
      r_seq    <= '0;
      r_buf    <= '0;
    end else if (i_load && !r_active) begin
      r_active <= 1'b1;
      r_idx    <= '0;
      r_seq    <= i_seq;
      r_buf    <= i_samples;
    end else if (r_active) begin
      r_active <= !w_last;
      r_idx    <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Data word j packs channel pair (2j-1, 2j-2), odd channel on top,
  // which is simply the j-1'th 32-bit slice of the flat buffer.
  always_comb begin
    w_word = {HDR_TAG, r_seq};
    for (int j = 1; j < FRAME_WORDS; j++) begin
      if (r_idx == IDX_W'(j))
        w_word = r_buf[WORD_W*(j-1) +: WORD_W];
    end
  end

  assign o_din      = r_active ? w_word : '0;
  assign o_wr_en    = r_active & ~i_fifo_full;
  assign o_full_hit = r_active & i_fifo_full;
  assign o_busy     = r_active;
  assign o_last     = w_last;

endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: gathers one sample per ADC channel into a frame and
// writes header + 5 data words to the FIFO, for a programmed frame count.
// Ports: clk/rst; i_start + i_samples_count arm a run; io_bus carries ADC
// data/rdy in and FIFO din/wr_en out; o_busy, o_finished, o_drop_cnt,
// o_frame_cnt and sticky o_err report run status.
module adc_frame_packer
  import adc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [31:0]         i_samples_count,
  adc_frame_packer_if.master  io_bus,
  output logic                o_busy,
  output logic                o_finished,
  output logic [15:0]         o_drop_cnt,
  output logic [31:0]         o_frame_cnt,
  output logic                o_err
);

  state_t             r_state;
  state_t             w_next;

  logic [31:0]        r_target;
  logic [31:0]        r_frame_cnt;
  logic [15:0]        r_drop_cnt;
  logic               r_err;

  logic [NUM_CH-1:0]  r_mask;
  logic [NUM_CH-1:0]  w_mask_nxt;
  logic [FRAME_W-1:0] r_ch;

  logic               w_start_ok;
  logic               w_cap_en;
  logic               w_take;
  logic               w_accept;
  logic               w_drop;
  logic               w_em_busy;
  logic               w_em_last;
  logic               w_full_hit;
  logic               w_run_end;

  assign w_start_ok = (r_state == S_IDLE) & i_start;

  // Capture stops once the run's frame quota has been written.
  assign w_cap_en = (r_state == S_RUN) & (r_frame_cnt != r_target);

  assign w_take   = (r_state == S_RUN) & (&r_mask);
  assign w_accept = w_take & ~w_em_busy &
                    (io_bus.fifo_wr_count <= FIFO_THRESH);
  assign w_drop   = w_take & ~w_accept;

  assign w_run_end = w_em_last & (r_frame_cnt + 32'd1 == r_target);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_busy     = 1'b0;
    o_finished = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start)
          w_next = (i_samples_count == 32'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_run_end) w_next = S_DONE;
      end
      S_DONE: begin
        o_busy     = 1'b1;
        o_finished = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A take clears the mask first; rdy bits in the same cycle then open
  // the next frame.
  always_comb begin
    w_mask_nxt = '0;
    if (w_cap_en)
      w_mask_nxt = (w_take ? '0 : r_mask) | io_bus.rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
      r_ch   <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_cap_en && io_bus.rdy[k])
          r_ch[k*SAMPLE_W +: SAMPLE_W] <=
            io_bus.data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target    <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err       <= 1'b0;
    end else if (w_start_ok) begin
      r_target    <= i_samples_count;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_drop)     r_drop_cnt  <= sat_inc16(r_drop_cnt);
      if (w_em_last)  r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_full_hit) r_err       <= 1'b1;
    end
  end

  adc_frame_emitter u_emit (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_seq       (r_frame_cnt[15:0]),
    .i_samples   (r_ch),
    .i_fifo_full (io_bus.fifo_full),
    .o_busy      (w_em_busy),
    .o_last      (w_em_last),
    .o_full_hit  (w_full_hit),
    .o_din       (io_bus.fifo_din),
    .o_wr_en     (io_bus.fifo_wr_en)
  );

  assign o_drop_cnt  = r_drop_cnt;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err       = r_err;

endmodule
